// File: rtl/diad_pipe_pkg.sv
// Shared defaults and stage index names for the diad in-order pipeline.
package diad_pipe_pkg;

  localparam int unsigned DFLT_SIZE_ADDR = 24;
  localparam int unsigned DFLT_SIZE_DATA = 24;
  localparam int unsigned DFLT_NUM_STG   = 8;
  localparam int unsigned DFLT_SIZE_CNT  = 32;
  localparam int unsigned DFLT_RST_PC    = 0;

  localparam int unsigned STG_IA = 0;
  localparam int unsigned STG_IF = 1;
  localparam int unsigned STG_ID = 2;
  localparam int unsigned STG_EX = 3;
  localparam int unsigned STG_MA = 4;
  localparam int unsigned STG_MO = 5;
  localparam int unsigned STG_RA = 6;
  localparam int unsigned STG_RO = 7;

endpackage

// File: rtl/diad_pipe_stage.sv
// One {valid, pc, instr} pipeline register. Kill beats hold, hold beats bubble, bubble beats load.
module diad_pipe_stage #(
  parameter int unsigned SIZE_ADDR = 24,
  parameter int unsigned SIZE_DATA = 24
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 kill_i,
  input  logic                 hold_i,
  input  logic                 bubble_i,
  input  logic                 valid_i,
  input  logic [SIZE_ADDR-1:0] pc_i,
  input  logic [SIZE_DATA-1:0] instr_i,
  output logic                 valid_o,
  output logic [SIZE_ADDR-1:0] pc_o,
  output logic [SIZE_DATA-1:0] instr_o
);

  logic                 valid_q;
  logic [SIZE_ADDR-1:0] pc_q;
  logic [SIZE_DATA-1:0] instr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else if (kill_i) begin
      valid_q <= 1'b0;
    end else if (!hold_i) begin
      if (bubble_i) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= valid_i;
        pc_q    <= pc_i;
        instr_q <= instr_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/diad_pipe.sv
// diad in-order pipeline skeleton: PC generation, fetch, stall/flush control,
// retire port and saturating performance counters.
module diad_pipe
  import diad_pipe_pkg::*;
#(
  parameter int unsigned           SIZE_ADDR = DFLT_SIZE_ADDR,
  parameter int unsigned           SIZE_DATA = DFLT_SIZE_DATA,
  parameter int unsigned           NUM_STG   = DFLT_NUM_STG,
  parameter logic [SIZE_ADDR-1:0]  RST_PC    = SIZE_ADDR'(DFLT_RST_PC),
  parameter int unsigned           SIZE_CNT  = DFLT_SIZE_CNT
) (
  input  logic                           iw_clk,
  input  logic                           iw_rst_n,
  input  logic [NUM_STG-1:0]             iw_stall,
  input  logic                           iw_flush_valid,
  input  logic [$clog2(NUM_STG)-1:0]     iw_flush_stg,
  input  logic [SIZE_ADDR-1:0]           iw_flush_pc,
  output logic [SIZE_ADDR-1:0]           ow_mem_addr,
  input  logic [SIZE_DATA-1:0]           iw_mem_rdata,
  output logic [NUM_STG-1:0]             ow_stg_valid,
  output logic [NUM_STG*SIZE_ADDR-1:0]   ow_stg_pc,
  output logic [NUM_STG*SIZE_DATA-1:0]   ow_stg_instr,
  output logic                           ow_retire_valid,
  output logic [SIZE_ADDR-1:0]           ow_retire_pc,
  output logic [SIZE_DATA-1:0]           ow_retire_instr,
  output logic [SIZE_CNT-1:0]            ow_retire_cnt,
  output logic [SIZE_CNT-1:0]            ow_stall_cnt
);

  logic [NUM_STG-1:0]   hold;
  logic [NUM_STG-1:0]   kill;
  logic [NUM_STG-1:0]   in_valid;
  logic [NUM_STG-1:0]   stg_valid;
  logic [SIZE_ADDR-1:0] stg_pc    [NUM_STG];
  logic [SIZE_DATA-1:0] stg_instr [NUM_STG];

  logic [31:0]          flush_s;
  logic                 flush_eff;

  logic                 valid0_q;
  logic [SIZE_ADDR-1:0] pc0_q, pc0_d;
  logic [SIZE_CNT-1:0]  retire_cnt_q, stall_cnt_q;

  assign flush_s   = 32'(iw_flush_stg);
  assign flush_eff = iw_flush_valid && (flush_s >= 32'd1) && (flush_s < NUM_STG);

  // A stall anywhere downstream freezes every stage above it; the flush stage
  // itself obeys hold but admits only a bubble when it does load.
  always_comb begin
    hold     = '0;
    kill     = '0;
    in_valid = '0;
    for (int unsigned k = 0; k < NUM_STG; k++) begin
      hold[k] = |(iw_stall >> k);
    end
    for (int unsigned k = 1; k < NUM_STG; k++) begin
      kill[k]     = flush_eff && (k < flush_s);
      in_valid[k] = stg_valid[k-1] && !(flush_eff && (k == flush_s));
    end
  end

  always_comb begin
    pc0_d = pc0_q;
    if (flush_eff)      pc0_d = iw_flush_pc;
    else if (!valid0_q) pc0_d = RST_PC;
    else if (!hold[0])  pc0_d = pc0_q + SIZE_ADDR'(1);
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      valid0_q <= 1'b0;
      pc0_q    <= '0;
    end else begin
      valid0_q <= 1'b1;
      pc0_q    <= pc0_d;
    end
  end

  assign ow_mem_addr  = pc0_d;
  assign stg_valid[0] = valid0_q;
  assign stg_pc[0]    = pc0_q;
  assign stg_instr[0] = '0;

  for (genvar k = 1; k < NUM_STG; k++) begin : g_stg
    diad_pipe_stage #(
      .SIZE_ADDR (SIZE_ADDR),
      .SIZE_DATA (SIZE_DATA)
    ) u_stg (
      .clk_i    (iw_clk),
      .rst_ni   (iw_rst_n),
      .kill_i   (kill[k]),
      .hold_i   (hold[k]),
      .bubble_i (hold[k-1]),
      .valid_i  (in_valid[k]),
      .pc_i     (stg_pc[k-1]),
      .instr_i  ((k == STG_IF) ? iw_mem_rdata : stg_instr[k-1]),
      .valid_o  (stg_valid[k]),
      .pc_o     (stg_pc[k]),
      .instr_o  (stg_instr[k])
    );
  end

  always_comb begin
    ow_stg_valid = stg_valid;
    ow_stg_pc    = '0;
    ow_stg_instr = '0;
    for (int unsigned k = 0; k < NUM_STG; k++) begin
      ow_stg_pc[k*SIZE_ADDR +: SIZE_ADDR]    = stg_pc[k];
      ow_stg_instr[k*SIZE_DATA +: SIZE_DATA] = stg_instr[k];
    end
  end

  assign ow_retire_valid = stg_valid[NUM_STG-1] && !iw_stall[NUM_STG-1];
  assign ow_retire_pc    = stg_pc[NUM_STG-1];
  assign ow_retire_instr = stg_instr[NUM_STG-1];

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (ow_retire_valid && (retire_cnt_q != '1)) retire_cnt_q <= retire_cnt_q + SIZE_CNT'(1);
      if ((|iw_stall) && (stall_cnt_q != '1))      stall_cnt_q  <= stall_cnt_q + SIZE_CNT'(1);
    end
  end

  assign ow_retire_cnt = retire_cnt_q;
  assign ow_stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_diad_pipe.sv
// Directed bench for diad_pipe: fill, stall, flush, wrap, saturation and async reset.
module tb_diad_pipe;

  localparam int N  = 8;
  localparam int AW = 24;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  stall;
  logic          flush_valid;
  logic [2:0]    flush_stg;
  logic [AW-1:0] flush_pc;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [N-1:0]  stg_valid;
  logic [N*AW-1:0] stg_pc;
  logic [N*DW-1:0] stg_instr;
  logic          retire_valid;
  logic [AW-1:0] retire_pc;
  logic [DW-1:0] retire_instr;
  logic [31:0]   retire_cnt, stall_cnt;

  logic [AW-1:0]   s_mem_addr;
  logic [N-1:0]    s_stg_valid;
  logic [N*AW-1:0] s_stg_pc;
  logic [N*DW-1:0] s_stg_instr;
  logic            s_retire_valid;
  logic [AW-1:0]   s_retire_pc;
  logic [DW-1:0]   s_retire_instr;
  logic [2:0]      s_retire_cnt, s_stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Synchronous instruction memory: word = addr ^ 0xA5A5A5
  always @(posedge clk) mem_rdata <= mem_addr ^ 24'hA5A5A5;

  diad_pipe dut (
    .iw_clk(clk), .iw_rst_n(rst_n), .iw_stall(stall),
    .iw_flush_valid(flush_valid), .iw_flush_stg(flush_stg), .iw_flush_pc(flush_pc),
    .ow_mem_addr(mem_addr), .iw_mem_rdata(mem_rdata),
    .ow_stg_valid(stg_valid), .ow_stg_pc(stg_pc), .ow_stg_instr(stg_instr),
    .ow_retire_valid(retire_valid), .ow_retire_pc(retire_pc), .ow_retire_instr(retire_instr),
    .ow_retire_cnt(retire_cnt), .ow_stall_cnt(stall_cnt)
  );

  diad_pipe #(.SIZE_CNT(3)) dut_sat (
    .iw_clk(clk), .iw_rst_n(rst_n), .iw_stall(stall),
    .iw_flush_valid(flush_valid), .iw_flush_stg(flush_stg), .iw_flush_pc(flush_pc),
    .ow_mem_addr(s_mem_addr), .iw_mem_rdata(mem_rdata),
    .ow_stg_valid(s_stg_valid), .ow_stg_pc(s_stg_pc), .ow_stg_instr(s_stg_instr),
    .ow_retire_valid(s_retire_valid), .ow_retire_pc(s_retire_pc), .ow_retire_instr(s_retire_instr),
    .ow_retire_cnt(s_retire_cnt), .ow_stall_cnt(s_stall_cnt)
  );

  function automatic logic [AW-1:0] pc_of(input int k);
    return stg_pc[k*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] instr_of(input int k);
    return stg_instr[k*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = '0; flush_valid = 1'b0; flush_stg = '0; flush_pc = '0;
    tick(); tick();
    n_chk++; if (stg_valid !== 8'h00) begin n_fail++; $display("FAIL reset_valid got %h exp 00", stg_valid); end
    n_chk++; if (pc_of(0) !== 24'h0) begin n_fail++; $display("FAIL reset_pc0 got %h exp 000000", pc_of(0)); end
    n_chk++; if (retire_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_retire_cnt got %0d exp 0", retire_cnt); end
    n_chk++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
    n_chk++; if (mem_addr !== 24'h0) begin n_fail++; $display("FAIL reset_mem_addr got %h exp 000000", mem_addr); end
    n_chk++; if (retire_valid !== 1'b0) begin n_fail++; $display("FAIL reset_retire_valid got %b exp 0", retire_valid); end
  endtask

  task automatic test_fill();
    logic [8:0] expv;
    rst_n = 1'b1;
    #1;
    n_chk++; if (mem_addr !== 24'h0) begin n_fail++; $display("FAIL fill_first_addr got %h exp 000000", mem_addr); end
    for (int e = 1; e <= 8; e++) begin
      tick();
      expv = (9'd1 << e) - 9'd1;
      n_chk++; if (stg_valid !== expv[7:0]) begin n_fail++; $display("FAIL fill_valid e%0d got %h exp %h", e, stg_valid, expv[7:0]); end
      n_chk++; if (pc_of(0) !== 24'(e-1)) begin n_fail++; $display("FAIL fill_pc0 e%0d got %h exp %h", e, pc_of(0), 24'(e-1)); end
      n_chk++; if (retire_valid !== (e == 8)) begin n_fail++; $display("FAIL fill_retire_valid e%0d got %b exp %b", e, retire_valid, (e == 8)); end
      if (e == 2) begin
        n_chk++; if (instr_of(1) !== 24'hA5A5A5) begin n_fail++; $display("FAIL fill_if_instr got %h exp a5a5a5", instr_of(1)); end
      end
    end
    n_chk++; if (retire_pc !== 24'h0) begin n_fail++; $display("FAIL fill_retire_pc got %h exp 000000", retire_pc); end
    n_chk++; if (retire_instr !== 24'hA5A5A5) begin n_fail++; $display("FAIL fill_retire_instr got %h exp a5a5a5", retire_instr); end
    n_chk++; if (retire_cnt !== 32'd0) begin n_fail++; $display("FAIL fill_cnt_before got %0d exp 0", retire_cnt); end
    tick();
    n_chk++; if (retire_cnt !== 32'd1) begin n_fail++; $display("FAIL fill_cnt_after got %0d exp 1", retire_cnt); end
    n_chk++; if (retire_pc !== 24'h1) begin n_fail++; $display("FAIL fill_retire_pc1 got %h exp 000001", retire_pc); end
    n_chk++; if (retire_instr !== 24'hA5A5A4) begin n_fail++; $display("FAIL fill_retire_instr1 got %h exp a5a5a4", retire_instr); end
  endtask

  task automatic test_stall();
    stall = 8'h08;
    #1;
    n_chk++; if (mem_addr !== 24'h8) begin n_fail++; $display("FAIL stall_addr0 got %h exp 000008", mem_addr); end
    tick();
    n_chk++; if (pc_of(0) !== 24'h8) begin n_fail++; $display("FAIL stall_pc0_a got %h exp 000008", pc_of(0)); end
    n_chk++; if (pc_of(3) !== 24'h5) begin n_fail++; $display("FAIL stall_pc3 got %h exp 000005", pc_of(3)); end
    n_chk++; if (stg_valid[4] !== 1'b0) begin n_fail++; $display("FAIL stall_bubble_a got %b exp 0", stg_valid[4]); end
    n_chk++; if (pc_of(7) !== 24'h2) begin n_fail++; $display("FAIL stall_pc7 got %h exp 000002", pc_of(7)); end
    n_chk++; if (stall_cnt !== 32'd1) begin n_fail++; $display("FAIL stall_cnt_a got %0d exp 1", stall_cnt); end
    tick();
    n_chk++; if (pc_of(0) !== 24'h8) begin n_fail++; $display("FAIL stall_pc0_b got %h exp 000008", pc_of(0)); end
    n_chk++; if (mem_addr !== 24'h8) begin n_fail++; $display("FAIL stall_addr1 got %h exp 000008", mem_addr); end
    n_chk++; if (stg_valid[4] !== 1'b0) begin n_fail++; $display("FAIL stall_bubble_b got %b exp 0", stg_valid[4]); end
    n_chk++; if (stall_cnt !== 32'd2) begin n_fail++; $display("FAIL stall_cnt_b got %0d exp 2", stall_cnt); end
    stall = '0;
    tick();
    n_chk++; if (retire_valid !== 1'b1 || retire_pc !== 24'h4) begin n_fail++; $display("FAIL stall_ret_e12 got %b/%h exp 1/000004", retire_valid, retire_pc); end
    tick();
    n_chk++; if (retire_valid !== 1'b0) begin n_fail++; $display("FAIL stall_gap1 got %b exp 0", retire_valid); end
    tick();
    n_chk++; if (retire_valid !== 1'b0) begin n_fail++; $display("FAIL stall_gap2 got %b exp 0", retire_valid); end
    tick();
    n_chk++; if (retire_valid !== 1'b1 || retire_pc !== 24'h5) begin n_fail++; $display("FAIL stall_ret_e15 got %b/%h exp 1/000005", retire_valid, retire_pc); end
    n_chk++; if (retire_cnt !== 32'd5) begin n_fail++; $display("FAIL stall_retire_cnt got %0d exp 5", retire_cnt); end
    n_chk++; if (stg_valid !== 8'hFF) begin n_fail++; $display("FAIL stall_refill got %h exp ff", stg_valid); end
  endtask

  task automatic test_flush();
    flush_valid = 1'b1; flush_stg = 3'd3; flush_pc = 24'h000100;
    #1;
    n_chk++; if (mem_addr !== 24'h100) begin n_fail++; $display("FAIL flush_addr got %h exp 000100", mem_addr); end
    tick();
    flush_valid = 1'b0;
    n_chk++; if (pc_of(0) !== 24'h100) begin n_fail++; $display("FAIL flush_pc0 got %h exp 000100", pc_of(0)); end
    n_chk++; if (stg_valid !== 8'hF1) begin n_fail++; $display("FAIL flush_valid got %h exp f1", stg_valid); end
    n_chk++; if (pc_of(4) !== 24'h9) begin n_fail++; $display("FAIL flush_pc4 got %h exp 000009", pc_of(4)); end
    tick();
    n_chk++; if (pc_of(1) !== 24'h100) begin n_fail++; $display("FAIL flush_pc1 got %h exp 000100", pc_of(1)); end
    n_chk++; if (instr_of(1) !== 24'hA5A4A5) begin n_fail++; $display("FAIL flush_instr1 got %h exp a5a4a5", instr_of(1)); end
    n_chk++; if (stg_valid !== 8'hE3) begin n_fail++; $display("FAIL flush_valid2 got %h exp e3", stg_valid); end
  endtask

  task automatic test_flush_stall();
    flush_valid = 1'b1; flush_stg = 3'd3; flush_pc = 24'h000200; stall = 8'h20;
    #1;
    n_chk++; if (mem_addr !== 24'h200) begin n_fail++; $display("FAIL fstall_addr got %h exp 000200", mem_addr); end
    tick();
    n_chk++; if (pc_of(0) !== 24'h200) begin n_fail++; $display("FAIL fstall_pc0 got %h exp 000200", pc_of(0)); end
    n_chk++; if (stg_valid !== 8'hA1) begin n_fail++; $display("FAIL fstall_valid got %h exp a1", stg_valid); end
    n_chk++; if (pc_of(5) !== 24'h9) begin n_fail++; $display("FAIL fstall_pc5 got %h exp 000009", pc_of(5)); end
    n_chk++; if (pc_of(3) !== 24'hA) begin n_fail++; $display("FAIL fstall_pc3 got %h exp 00000a", pc_of(3)); end
    n_chk++; if (stall_cnt !== 32'd3) begin n_fail++; $display("FAIL fstall_stall_cnt got %0d exp 3", stall_cnt); end
    flush_stg = 3'd0; flush_pc = 24'h000300; stall = '0;
    #1;
    n_chk++; if (mem_addr !== 24'h201) begin n_fail++; $display("FAIL fignore_addr got %h exp 000201", mem_addr); end
    tick();
    flush_valid = 1'b0;
    n_chk++; if (pc_of(0) !== 24'h201) begin n_fail++; $display("FAIL fignore_pc0 got %h exp 000201", pc_of(0)); end
    n_chk++; if (stg_valid !== 8'h43) begin n_fail++; $display("FAIL fignore_valid got %h exp 43", stg_valid); end
    n_chk++; if (pc_of(6) !== 24'h9) begin n_fail++; $display("FAIL fignore_pc6 got %h exp 000009", pc_of(6)); end
    n_chk++; if (instr_of(1) !== 24'hA5A7A5) begin n_fail++; $display("FAIL fignore_instr1 got %h exp a5a7a5", instr_of(1)); end
    n_chk++; if (retire_cnt !== 32'd9) begin n_fail++; $display("FAIL fignore_retire_cnt got %0d exp 9", retire_cnt); end
  endtask

  task automatic test_wrap();
    flush_valid = 1'b1; flush_stg = 3'd1; flush_pc = 24'hFFFFFF;
    tick();
    flush_valid = 1'b0;
    #1;
    n_chk++; if (pc_of(0) !== 24'hFFFFFF) begin n_fail++; $display("FAIL wrap_pc0_a got %h exp ffffff", pc_of(0)); end
    n_chk++; if (stg_valid[1] !== 1'b0) begin n_fail++; $display("FAIL wrap_s1_forced got %b exp 0", stg_valid[1]); end
    n_chk++; if (mem_addr !== 24'h0) begin n_fail++; $display("FAIL wrap_addr got %h exp 000000", mem_addr); end
    tick();
    n_chk++; if (pc_of(0) !== 24'h0) begin n_fail++; $display("FAIL wrap_pc0_b got %h exp 000000", pc_of(0)); end
    n_chk++; if (pc_of(1) !== 24'hFFFFFF || stg_valid[1] !== 1'b1) begin n_fail++; $display("FAIL wrap_s1 got %h/%b exp ffffff/1", pc_of(1), stg_valid[1]); end
    n_chk++; if (instr_of(1) !== 24'h5A5A5A) begin n_fail++; $display("FAIL wrap_instr1 got %h exp 5a5a5a", instr_of(1)); end
    tick();
    n_chk++; if (pc_of(0) !== 24'h1) begin n_fail++; $display("FAIL wrap_pc0_c got %h exp 000001", pc_of(0)); end
  endtask

  task automatic test_async_reset();
    n_chk++; if (s_retire_cnt !== 3'd7) begin n_fail++; $display("FAIL sat_retire_cnt got %0d exp 7", s_retire_cnt); end
    n_chk++; if (s_stall_cnt !== 3'd3) begin n_fail++; $display("FAIL sat_stall_cnt got %0d exp 3", s_stall_cnt); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (stg_valid !== 8'h00) begin n_fail++; $display("FAIL areset_valid got %h exp 00", stg_valid); end
    n_chk++; if (retire_cnt !== 32'd0 || stall_cnt !== 32'd0) begin n_fail++; $display("FAIL areset_cnts got %0d/%0d exp 0/0", retire_cnt, stall_cnt); end
    n_chk++; if (retire_valid !== 1'b0) begin n_fail++; $display("FAIL areset_retire got %b exp 0", retire_valid); end
    n_chk++; if (mem_addr !== 24'h0) begin n_fail++; $display("FAIL areset_addr got %h exp 000000", mem_addr); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_chk++; if (pc_of(0) !== 24'h0 || stg_valid !== 8'h01) begin n_fail++; $display("FAIL areset_restart got %h/%h exp 000000/01", pc_of(0), stg_valid); end
    n_chk++; if (mem_addr !== 24'h1) begin n_fail++; $display("FAIL areset_next_addr got %h exp 000001", mem_addr); end
  endtask

  initial begin
    rst_n = 1'b0; stall = '0; flush_valid = 1'b0; flush_stg = '0; flush_pc = '0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_stall();
    test_flush();
    test_flush_stall();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
